// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: register bus between the CPU data path and the UART receiver
interface uart_rx_fifo_if;
    logic [63:0] addr;
    logic [2:0]  rd_ctrl;
    logic [2:0]  wr_ctrl;
    logic [63:0] data_in;
    logic [63:0] data_out;
    logic        valid;
    modport master (output addr, rd_ctrl, wr_ctrl, data_in, input data_out, valid);
    modport slave  (input addr, rd_ctrl, wr_ctrl, data_in, output data_out, valid);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small FIFO drained through a register bus
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           uart_rxd,
    uart_rx_fifo_if.slave  bus,
    output logic           rx_irq
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta, rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic          ovr, ferr, prev_rd;
    logic [3:0]    prev_off, off;
    logic          rd, wr, first_rd, empty, full, pop, push, stop_tick, ovr_ev, ferr_ev;
    logic          unused;

    assign off       = bus.addr[3:0];
    assign rd        = |bus.rd_ctrl;
    assign wr        = |bus.wr_ctrl;
    assign first_rd  = rd && !(prev_rd && prev_off == off);
    assign count     = wr_ptr - rd_ptr;
    assign empty     = count == '0;
    assign full      = count == (AW + 1)'(FIFO_DEPTH);
    assign pop       = first_rd && off == 4'h0 && !empty;
    assign stop_tick = state == STOP && cnt == FULL;
    assign push      = stop_tick && rxs && (!full || pop);
    assign ovr_ev    = stop_tick && rxs && full && !pop;
    assign ferr_ev   = stop_tick && !rxs;
    assign rx_irq    = !empty;
    assign unused    = ^{bus.addr[63:4], bus.data_in[63:4], bus.data_in[1:0]};

    // two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rxs, rx_meta} <= 2'b11;
        else        {rxs, rx_meta} <= {rx_meta, uart_rxd};

    // receive state machine: mid-bit sampling, LSB first
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE:  if (!rxs) begin
                           cnt   <= '0;
                           state <= START;
                       end
                START: if (cnt == HALF) begin
                           cnt     <= '0;
                           bit_idx <= '0;
                           state   <= rxs ? IDLE : DATA;
                       end else cnt <= cnt + 1'b1;
                DATA:  if (cnt == FULL) begin
                           cnt     <= '0;
                           shreg   <= {rxs, shreg[7:1]};
                           bit_idx <= bit_idx + 1'b1;
                           if (bit_idx == 3'd7) state <= STOP;
                       end else cnt <= cnt + 1'b1;
                STOP:  if (cnt == FULL) begin
                           cnt   <= '0;
                           state <= IDLE;
                       end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end

    // sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_ev  | (ovr  & !(wr && off == 4'h8 && bus.data_in[2]));
            ferr <= ferr_ev | (ferr & !(wr && off == 4'h8 && bus.data_in[3]));
        end

    // registered read port; a held RXDATA strobe keeps the byte already popped
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.data_out <= '0;
            bus.valid    <= 1'b0;
            prev_rd      <= 1'b0;
            prev_off     <= '0;
        end else begin
            bus.valid <= rd;
            prev_rd   <= rd;
            prev_off  <= off;
            if (rd)
                bus.data_out <= off == 4'h0 ? (first_rd ? (empty ? '0 : {55'b0, 1'b1, mem[rd_ptr[AW-1:0]]}) : bus.data_out)
                              : off == 4'h8 ? {56'b0, 4'(count), ferr, ovr, full, !empty}
                              : '0;
        end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized bench with a queue-based model of the UART receive FIFO
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rxd = 1'b1;
    logic rx_irq;
    uart_rx_fifo_if bus();

    uart_rx_fifo #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .bus(bus), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    logic [7:0]  q[$];
    bit          m_ovr, m_ferr, exp_valid, prev_rd, stable;
    logic [3:0]  prev_off;
    logic [63:0] exp_data;
    int          pass_cnt = 0, tot = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tot++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [63:0] m_status();
        return {56'b0, 4'(q.size()), m_ferr, m_ovr, q.size() == 8, q.size() != 0};
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovr = 0;
        m_ferr = 0;
        exp_valid = 0;
        exp_data = '0;
        prev_rd = 0;
        prev_off = '0;
    endfunction

    function automatic void m_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) m_ferr = 1;
        else if (q.size() == 8) m_ovr = 1;
        else q.push_back(b);
    endfunction

    // model of the register port, evaluated on the same edge the design sees
    always @(posedge clk) if (rst_n) begin : mdl
        logic [3:0] o;
        bit r, first;
        o = bus.addr[3:0];
        r = bus.rd_ctrl != 0;
        first = !(prev_rd && prev_off == o);
        if (r) begin
            if (o == 4'h0) begin
                if (first) exp_data = q.size() != 0 ? {55'b0, 1'b1, q.pop_front()} : 64'h0;
            end else if (o == 4'h8) exp_data = m_status();
            else exp_data = 64'h0;
        end
        if (bus.wr_ctrl != 0 && o == 4'h8) begin
            if (bus.data_in[2]) m_ovr = 0;
            if (bus.data_in[3]) m_ferr = 0;
        end
        exp_valid = r;
        prev_rd = r;
        prev_off = o;
    end

    // per-cycle comparison against the model
    always @(negedge clk) if (rst_n) begin
        check("valid", 64'(bus.valid), 64'(exp_valid));
        if (exp_valid) check("data_out", bus.data_out, exp_data);
        if (stable) check("rx_irq", 64'(rx_irq), 64'(q.size() != 0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        stable = 0;
        uart_rxd = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (16) tick();
        end
        uart_rxd = stop_ok;
        repeat (16) tick();
        uart_rxd = 1'b1;
        m_frame(b, stop_ok);
        stable = 1;
        repeat (stop_ok ? 4 : 20) tick();
    endtask

    task automatic bus_rd(input logic [3:0] o, output logic [63:0] got);
        bus.addr = {32'($urandom), 28'($urandom), o};
        bus.rd_ctrl = 3'($urandom_range(1, 7));
        tick();
        bus.rd_ctrl = 3'd0;
        got = bus.data_out;
        tick();
    endtask

    task automatic bus_wr(input logic [3:0] o, input logic [63:0] d);
        bus.addr = {32'($urandom), 28'($urandom), o};
        bus.data_in = d;
        bus.wr_ctrl = 3'($urandom_range(1, 7));
        tick();
        bus.wr_ctrl = 3'd0;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [3:0] o, input logic [63:0] want);
        logic [63:0] g;
        bus_rd(o, g);
        check(name, g, want);
    endtask

    initial begin
        logic [63:0] g;
        bus.addr = '0;
        bus.rd_ctrl = '0;
        bus.wr_ctrl = '0;
        bus.data_in = '0;
        m_reset();
        stable = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", bus.data_out, 64'h0);
        check("rst_valid", 64'(bus.valid), 64'h0);
        check("rst_irq", 64'(rx_irq), 64'h0);
        rst_n = 1'b1;
        stable = 1;
        tick();
        rd_chk("status_init", 4'h8, 64'h0);

        send(8'hA5, 1);
        check("a5_irq", 64'(rx_irq), 64'h1);
        rd_chk("a5_status", 4'h8, 64'h11);
        bus_rd(4'h0, g);
        check("a5_data", g, 64'h1A5);
        rd_chk("a5_status_after", 4'h8, 64'h00);
        check("a5_irq_after", 64'(rx_irq), 64'h0);

        for (int i = 0; i < 8; i++) send(8'(i), 1);
        send(8'hFF, 1);
        rd_chk("ovf_status", 4'h8, 64'h87);
        for (int i = 0; i < 8; i++) rd_chk("ovf_data", 4'h0, 64'h100 + 64'(i));
        rd_chk("empty_read", 4'h0, 64'h0);
        rd_chk("ovr_only", 4'h8, 64'h04);
        bus_wr(4'h8, 64'h4);
        rd_chk("ovr_clear", 4'h8, 64'h00);

        send(8'h3C, 0);
        rd_chk("ferr_status", 4'h8, 64'h08);
        bus_wr(4'h8, 64'hC);
        rd_chk("ferr_clear", 4'h8, 64'h00);

        uart_rxd = 1'b0;
        repeat (5) tick();
        uart_rxd = 1'b1;
        repeat (30) tick();
        rd_chk("glitch_status", 4'h8, 64'h00);
        send(8'h5A, 1);
        rd_chk("after_glitch", 4'h0, 64'h15A);

        send(8'h11, 1);
        send(8'h22, 1);
        bus.addr = 64'h0;
        bus.rd_ctrl = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_data", bus.data_out, 64'h111);
            check("held_valid", 64'(bus.valid), 64'h1);
        end
        bus.rd_ctrl = 3'd0;
        tick();
        rd_chk("held_status", 4'h8, 64'h11);
        rd_chk("held_next", 4'h0, 64'h122);

        send(8'h33, 1);
        stable = 0;
        uart_rxd = 1'b0;
        repeat (16) tick();
        for (int i = 0; i < 4; i++) begin
            uart_rxd = 1'($urandom);
            repeat (16) tick();
        end
        uart_rxd = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        m_reset();
        #1;
        check("midrst_data_out", bus.data_out, 64'h0);
        check("midrst_valid", 64'(bus.valid), 64'h0);
        check("midrst_irq", 64'(rx_irq), 64'h0);
        uart_rxd = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        stable = 1;
        repeat (40) tick();
        rd_chk("midrst_status", 4'h8, 64'h00);
        send(8'h7E, 1);
        rd_chk("midrst_next", 4'h0, 64'h17E);

        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), $urandom_range(0, 7) != 0);
            repeat ($urandom_range(0, 3)) begin
                case ($urandom_range(0, 3))
                    0: bus_rd(4'h0, g);
                    1: bus_rd(4'h8, g);
                    2: bus_wr(4'($urandom), 64'($urandom));
                    default: bus_rd(4'($urandom), g);
                endcase
            end
        end
        repeat (9) bus_rd(4'h0, g);
        rd_chk("final_status", 4'h8, m_status());

        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
